// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT frame sequencer.
// Holds the frame size, index width, FSM states and lane reorder helper.
package fft8_pkg;

  localparam int FFT_N = 8;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_UNLOAD
  } state_e;

  function automatic logic [IDX_W-1:0] bitrev3(
    input logic [IDX_W-1:0] i
  );
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/fft8_frame_buf.sv
// 8 x DW register file: single indexed write or whole-frame
// parallel load, with the full frame always visible on rdata_o.
module fft8_frame_buf
  import fft8_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic                  ld_i,
  input  logic [FFT_N*DW-1:0]   ldata_i,
  output logic [FFT_N*DW-1:0]   rdata_o
);

  logic [FFT_N-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (ld_i) begin
      mem_q <= ldata_i;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around the combinational 8-point FFT datapath.
// Define FFT8_BITREV_OUT_EN to stream results in bit-reversed lane order.
module fft8_frame_ctrl
  import fft8_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic                fft_start,
  output logic [FFT_N*DW-1:0] fft_in,
  input  logic [FFT_N*DW-1:0] fft_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  output logic                m_last,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt
);

  // Loaded with LAT+1 so the fft_start cycle itself is not counted.
  localparam logic [4:0] WAIT_INIT = 5'(LAT + 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]     rd_nx;
  logic [4:0]           wait_q, wait_d;
  logic                 s_ready_q, s_ready_d;
  logic                 start_q, start_d;
  logic                 m_valid_q, m_valid_d;
  logic [DW-1:0]        m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_we;
  logic                 out_ld;
  logic [FFT_N*DW-1:0]  out_q;

  function automatic logic [IDX_W-1:0] ord(
    input logic [IDX_W-1:0] i
  );
`ifdef FFT8_BITREV_OUT_EN
    return bitrev3(i);
`else
    return i;
`endif
  endfunction

  function automatic logic [DW-1:0] lane_of(
    input logic [FFT_N*DW-1:0] b,
    input logic [IDX_W-1:0]    i
  );
    return b[i*DW +: DW];
  endfunction

  assign rd_nx = rd_idx_q + IDX_W'(1);

  fft8_frame_buf #(.DW(DW)) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (in_we),
    .widx_i  (wr_idx_q),
    .wdata_i (s_data),
    .ld_i    (1'b0),
    .ldata_i ('0),
    .rdata_o (fft_in)
  );

  fft8_frame_buf #(.DW(DW)) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (1'b0),
    .widx_i  ('0),
    .wdata_i ('0),
    .ld_i    (out_ld),
    .ldata_i (fft_out),
    .rdata_o (out_q)
  );

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    wait_d    = wait_q;
    s_ready_d = s_ready_q;
    start_d   = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    in_we     = 1'b0;
    out_ld    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
        if (s_valid && s_ready_q) begin
          in_we    = 1'b1;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            s_ready_d = 1'b0;
            start_d   = 1'b1;
            wait_d    = WAIT_INIT;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (wait_q == 5'd0) begin
          out_ld    = 1'b1;
          rd_idx_d  = '0;
          m_valid_d = 1'b1;
          m_data_d  = lane_of(fft_out, ord('0));
          m_last_d  = 1'b0;
          state_d   = ST_UNLOAD;
        end else begin
          wait_d = wait_q - 5'd1;
        end
      end
      ST_UNLOAD: begin
        if (m_valid_q && m_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            s_ready_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            rd_idx_d = rd_nx;
            m_data_d = lane_of(out_q, ord(rd_nx));
            m_last_d = (rd_nx == LAST_IDX);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wait_q    <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wait_q    <= wait_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign fft_start = start_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule
